// File: rtl/ecc_vector_checker.sv
// ---------------------------------------------------------------------------
// ecc_vector_checker
//
// Stimulus sequencer and result checker for an ECC decoder. It walks an
// external combinational vector ROM, sends each encoded word to the decoder
// under test over a valid/ready handshake, waits for the decoder response
// and scores it against the expected fields stored in the ROM word.
//
// Optional feature macro: CHECKER_TIMEOUT_EN
//   defined   : a WAIT watchdog counts TIMEOUT_CYC cycles. A vector that
//               gets no response by then is scored as a fail, and the
//               sticky timeout flag is set.
//   undefined : WAIT holds until a response arrives. timeout is tied low.
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   start          in   begin a run (honoured in IDLE or DONE only)
//   vec_idx        out  ROM address
//   vec_data       in   ROM word {valid_true, decoded_true, encoded}
//   dut_enc        out  encoded word to the decoder
//   dut_enc_valid  out  dut_enc valid (SEND state)
//   dut_enc_ready  in   decoder accepts dut_enc
//   dut_rsp_valid  in   decoder response strobe
//   dut_dec        in   decoder output data
//   dut_dec_ok     in   decoder "decode valid" flag
//   busy           out  run in progress (FETCH/SEND/WAIT)
//   done           out  run complete, held until the next start
//   pass_cnt       out  vectors that matched
//   fail_cnt       out  vectors that mismatched or timed out
//   first_fail_idx out  index of the first failing vector
//   first_fail_vld out  first_fail_idx is meaningful
//   timeout        out  sticky: at least one vector timed out
// ---------------------------------------------------------------------------
module ecc_vector_checker #(
    parameter int ENC_W       = 21,
    parameter int DEC_W       = 16,
    parameter int NUM_VEC     = 5,
    parameter int IDX_W       = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1,
    parameter int CNT_W       = IDX_W + 1,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [IDX_W-1:0]     vec_idx,
    input  logic [DEC_W+ENC_W:0] vec_data,
    output logic [ENC_W-1:0]     dut_enc,
    output logic                 dut_enc_valid,
    input  logic                 dut_enc_ready,
    input  logic                 dut_rsp_valid,
    input  logic [DEC_W-1:0]     dut_dec,
    input  logic                 dut_dec_ok,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     pass_cnt,
    output logic [CNT_W-1:0]     fail_cnt,
    output logic [IDX_W-1:0]     first_fail_idx,
    output logic                 first_fail_vld,
    output logic                 timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   vec_idx_reg, vec_idx_next;
    logic [ENC_W-1:0]   enc_reg, enc_next;
    logic               exp_valid_reg, exp_valid_next;
    logic [DEC_W-1:0]   exp_dec_reg, exp_dec_next;
    logic [CNT_W-1:0]   pass_cnt_reg, pass_cnt_next;
    logic [CNT_W-1:0]   fail_cnt_reg, fail_cnt_next;
    logic [IDX_W-1:0]   ff_idx_reg, ff_idx_next;
    logic               ff_vld_reg, ff_vld_next;

    logic               wait_expired;
    logic               rsp_match;
    logic               resolve;
    logic               vec_fail;

    // dut_dec is only looked at when the vector is expected to decode.
    assign rsp_match = (dut_dec_ok == exp_valid_reg) &&
                       (!exp_valid_reg || (dut_dec == exp_dec_reg));

    // A vector is resolved by a response or by the watchdog; a response
    // arriving on the expiry cycle wins and is scored normally.
    assign resolve  = (state_reg == S_WAIT) && (dut_rsp_valid || wait_expired);
    assign vec_fail = !dut_rsp_valid || !rsp_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            vec_idx_reg   <= '0;
            enc_reg       <= '0;
            exp_valid_reg <= 1'b0;
            exp_dec_reg   <= '0;
            pass_cnt_reg  <= '0;
            fail_cnt_reg  <= '0;
            ff_idx_reg    <= '0;
            ff_vld_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            vec_idx_reg   <= vec_idx_next;
            enc_reg       <= enc_next;
            exp_valid_reg <= exp_valid_next;
            exp_dec_reg   <= exp_dec_next;
            pass_cnt_reg  <= pass_cnt_next;
            fail_cnt_reg  <= fail_cnt_next;
            ff_idx_reg    <= ff_idx_next;
            ff_vld_reg    <= ff_vld_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        vec_idx_next   = vec_idx_reg;
        enc_next       = enc_reg;
        exp_valid_next = exp_valid_reg;
        exp_dec_next   = exp_dec_reg;
        pass_cnt_next  = pass_cnt_reg;
        fail_cnt_next  = fail_cnt_reg;
        ff_idx_next    = ff_idx_reg;
        ff_vld_next    = ff_vld_reg;

        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next    = S_FETCH;
                    vec_idx_next  = '0;
                    pass_cnt_next = '0;
                    fail_cnt_next = '0;
                    ff_vld_next   = 1'b0;
                end
            end
            S_FETCH: begin
                // ROM is combinational: vec_data already reflects vec_idx.
                exp_valid_next = vec_data[DEC_W+ENC_W];
                exp_dec_next   = vec_data[ENC_W +: DEC_W];
                enc_next       = vec_data[ENC_W-1:0];
                state_next     = S_SEND;
            end
            S_SEND: begin
                if (dut_enc_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (resolve) begin
                    if (vec_fail) begin
                        fail_cnt_next = fail_cnt_reg + 1'b1;
                        if (!ff_vld_reg) begin
                            ff_idx_next = vec_idx_reg;
                            ff_vld_next = 1'b1;
                        end
                    end else begin
                        pass_cnt_next = pass_cnt_reg + 1'b1;
                    end
                    if (vec_idx_reg == IDX_W'(NUM_VEC - 1)) begin
                        state_next = S_DONE;
                    end else begin
                        vec_idx_next = vec_idx_reg + 1'b1;
                        state_next   = S_FETCH;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

`ifdef CHECKER_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TO_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic            timeout_reg, timeout_next;

    // wait_cnt_reg holds the number of WAIT cycles already completed, so
    // the limit is hit at the edge that ends the TIMEOUT_CYC-th WAIT cycle.
    assign wait_expired = (state_reg == S_WAIT) &&
                          (wait_cnt_reg == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
            timeout_reg  <= timeout_next;
        end
    end

    always_comb begin
        wait_cnt_next = '0;
        timeout_next  = timeout_reg;
        if ((state_reg == S_WAIT) && !wait_expired) begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
        end
        if (((state_reg == S_IDLE) || (state_reg == S_DONE)) && start) begin
            timeout_next = 1'b0;
        end else if (wait_expired && !dut_rsp_valid) begin
            timeout_next = 1'b1;
        end
    end

    assign timeout = timeout_reg;
`else
    // No watchdog: WAIT only ends on a response. TIMEOUT_CYC is referenced
    // here so the parameter list stays identical in both builds.
    assign wait_expired = 1'b0 && (TIMEOUT_CYC > 0);
    assign timeout      = 1'b0;
`endif

    assign vec_idx        = vec_idx_reg;
    assign dut_enc        = enc_reg;
    assign dut_enc_valid  = (state_reg == S_SEND);
    assign busy           = (state_reg == S_FETCH) || (state_reg == S_SEND) ||
                            (state_reg == S_WAIT);
    assign done           = (state_reg == S_DONE);
    assign pass_cnt       = pass_cnt_reg;
    assign fail_cnt       = fail_cnt_reg;
    assign first_fail_idx = ff_idx_reg;
    assign first_fail_vld = ff_vld_reg;

endmodule
